// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the RAM responder slice.
// Provides the protocol FSM state type and the address-width derivation
// used by both the responder and its register file.
package ram_pkg;

    // Protocol tracker states, sequentially encoded.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        FAULT = 3'd4
    } ram_state_t;

    // The address field is whatever is left of the word after the opcode.
    function automatic int calc_addr_w(input int word_w, input int op_w);
        return word_w - op_w;
    endfunction

endpackage

// File: rtl/ram_array.sv
// ram_array: plain register file with asynchronous read and synchronous,
// enabled write. Single shared address for read and write. Contents are
// not reset.
module ram_array #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    // Commit the write word on the rising edge when enabled.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ram_responder.sv
// ram_responder: memory-side responder for the processor RAM strobe bus.
// Latches the address on RAM_ADDRCP low, serves zero-latency reads and
// edge-committed writes, and tracks strobe protocol in a small FSM that
// raises a sticky proto_err on uncaptured accesses or read/write conflicts.
// Optional feature macro: RAM_WPROT_EN -- suppresses writes below WP_LIMIT
// and raises a sticky wp_err; when undefined wp_err is tied low.
module ram_responder
    import ram_pkg::*;
#(
    parameter  int WORD_W   = 8,
    parameter  int OP_W     = 3,
    parameter  int WP_LIMIT = 16,
    localparam int ADDR_W   = calc_addr_w(WORD_W, OP_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              RAM_ADDRCP,
    input  logic              RAM_NCE,
    input  logic              RAM_NOE,
    input  logic              RAM_NWE,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              rdata_en,
    output logic              proto_err,
    output logic              wp_err
);

    localparam logic [ADDR_W:0] WP_BOUND = (ADDR_W + 1)'(WP_LIMIT);

`ifdef RAM_WPROT_EN
    localparam bit WPROT_ON = 1'b1;
`else
    localparam bit WPROT_ON = 1'b0;
`endif

    logic [ADDR_W-1:0] addr_q;
    ram_state_t        state;
    ram_state_t        state_nxt;
    logic              proto_err_q;
    logic              err_set;

    logic              cap;
    logic              rd_stb;
    logic              wr_stb;
    logic              conflict;
    logic              wp_hit;
    logic              wp_block;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    // Strobe decode; chip enable high masks everything else.
    assign cap      = ~RAM_ADDRCP;
    assign rd_stb   = ~RAM_NCE & ~RAM_NOE &  RAM_NWE;
    assign wr_stb   = ~RAM_NCE & ~RAM_NWE &  RAM_NOE;
    assign conflict = ~RAM_NCE & ~RAM_NOE & ~RAM_NWE;

    // Protection compares against the address already latched, since that
    // is the one the access actually targets.
    assign wp_hit   = ({1'b0, addr_q} < WP_BOUND);
    assign wp_block = WPROT_ON & wp_hit;

    // Reset on the edge discards any write in flight.
    assign mem_we   = wr_stb & ~reset & ~wp_block;

    ram_array #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clock (clock),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (wdata),
        .rdata (mem_rdata)
    );

    // Read data is driven only during a clean read strobe, never under reset.
    assign rdata_en  = rd_stb & ~reset;
    assign rdata     = rdata_en ? mem_rdata : '0;
    assign proto_err = proto_err_q;

    // Next-state and error-raise decode for the protocol tracker.
    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        if (state == FAULT) begin
            state_nxt = FAULT;
        end else if (conflict) begin
            state_nxt = FAULT;
            err_set   = 1'b1;
        end else begin
            // An access started with no fresh address is still served but flagged.
            if ((rd_stb | wr_stb) && (state == IDLE)) begin
                err_set = 1'b1;
            end
            if (cap) begin
                state_nxt = ARMED;
            end else if (rd_stb) begin
                state_nxt = READ;
            end else if (wr_stb) begin
                state_nxt = WRITE;
            end else if ((state == READ) || (state == WRITE)) begin
                state_nxt = IDLE;
            end
        end
    end

    // State, latched address and sticky protocol error.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cap) begin
                addr_q <= addr;
            end
            if (err_set) begin
                proto_err_q <= 1'b1;
            end
        end
    end

`ifdef RAM_WPROT_EN
    logic wp_err_q;

    // Sticky flag for any write attempted into the protected region.
    always_ff @(posedge clock) begin
        if (reset) begin
            wp_err_q <= 1'b0;
        end else if (wr_stb && wp_hit) begin
            wp_err_q <= 1'b1;
        end
    end

    assign wp_err = wp_err_q;
`else
    assign wp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: scoreboard bench for ram_responder. Expected read words
// come from a bench-side memory model and are queued when a read strobe is
// driven, then popped against the DUT output in the strobe cycle.
module tb_ram_responder;
    import ram_pkg::*;

`ifdef RAM_WPROT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic       clock      = 1'b0;
    logic       reset      = 1'b1;
    logic       RAM_ADDRCP = 1'b1;
    logic       RAM_NCE    = 1'b1;
    logic       RAM_NOE    = 1'b1;
    logic       RAM_NWE    = 1'b1;
    logic [4:0] addr       = '0;
    logic [7:0] wdata      = '0;
    logic [7:0] rdata;
    logic       rdata_en;
    logic       proto_err;
    logic       wp_err;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] m_mem [32];
    logic [4:0] m_addr = '0;
    logic [7:0] sb_q [$];

    ram_responder #(
        .WORD_W   (8),
        .OP_W     (3),
        .WP_LIMIT (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .RAM_ADDRCP (RAM_ADDRCP),
        .RAM_NCE    (RAM_NCE),
        .RAM_NOE    (RAM_NOE),
        .RAM_NWE    (RAM_NWE),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .rdata_en   (rdata_en),
        .proto_err  (proto_err),
        .wp_err     (wp_err)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One bus cycle: drive strobes, compare combinational outputs mid-cycle,
    // then advance the model across the rising edge.
    task automatic drive(input logic cp, input logic ce, input logic oe, input logic we,
                         input logic [4:0] a, input logic [7:0] d);
        logic rd;
        logic wr;
        logic pushed;
        rd     = !ce && !oe && we;
        wr     = !ce && !we && oe;
        pushed = 1'b0;
        RAM_ADDRCP = cp;
        RAM_NCE    = ce;
        RAM_NOE    = oe;
        RAM_NWE    = we;
        addr       = a;
        wdata      = d;
        if (rd && !$isunknown(m_mem[m_addr])) begin
            sb_q.push_back(m_mem[m_addr]);
            pushed = 1'b1;
        end
        @(negedge clock);
        check("rdata_en", 32'(rdata_en), 32'(rd));
        if (pushed) begin
            check("rdata", 32'(rdata), 32'(sb_q.pop_front()));
        end else if (!rd) begin
            check("rdata_idle", 32'(rdata), 32'd0);
        end
        @(posedge clock);
        #1;
        if (wr && !(WP && (m_addr < 5'd16))) m_mem[m_addr] = d;
        if (!cp) m_addr = a;
    endtask

    task automatic idle();              drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 8'h00); endtask
    task automatic capture(input logic [4:0] a); drive(1'b0, 1'b1, 1'b1, 1'b1, a, 8'h00); endtask
    task automatic write(input logic [7:0] d);   drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, d); endtask
    task automatic read();              drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00); endtask

    // One cycle with reset high and the given strobes; nothing may be served or stored.
    task automatic reset_cycle(input logic ce, input logic oe, input logic we, input logic [7:0] d);
        reset      = 1'b1;
        RAM_ADDRCP = 1'b1;
        RAM_NCE    = ce;
        RAM_NOE    = oe;
        RAM_NWE    = we;
        wdata      = d;
        @(negedge clock);
        check("rst_rdata_en", 32'(rdata_en), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        @(posedge clock);
        #1;
        reset   = 1'b0;
        RAM_NCE = 1'b1;
        RAM_NOE = 1'b1;
        RAM_NWE = 1'b1;
        m_addr  = '0;
    endtask

    task automatic do_reset();
        reset_cycle(1'b1, 1'b1, 1'b1, 8'h00);
    endtask

    initial begin
        do_reset();
        check("rst_proto_err", 32'(proto_err), 32'd0);
        check("rst_wp_err", 32'(wp_err), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));

        // Seed address 0 for the uncaptured-read case later.
        capture(5'd0); write(8'h5A); idle();

        // Basic write then read at address 5.
        capture(5'd5); write(8'h3C); idle();
        capture(5'd5); read(); idle();
        check("basic_proto_err", 32'(proto_err), 32'd0);

        // Held write strobe: last word wins; held read repeats.
        capture(5'd20); write(8'h01); write(8'h02); write(8'h03); idle();
        capture(5'd20); read(); read(); idle();

        // Write visible to a read strobe on the very next cycle.
        capture(5'd21); write(8'h44); read(); idle();

        // Capture in the same cycle as a write: old address is written.
        capture(5'd9); write(8'h99); idle();
        capture(5'd2);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 8'hE2);
        read(); idle();
        capture(5'd2); read(); idle();
        check("same_cycle_proto_err", 32'(proto_err), 32'd0);

        // Chip enable high masks an otherwise conflicting strobe pair.
        capture(5'd20);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 8'hFF);
        idle(); read(); idle();
        check("nce_proto_err", 32'(proto_err), 32'd0);
        check("nce_state", 32'(dut.state), 32'(IDLE));

        // Write protection boundary.
        capture(5'd3); write(8'hAA); idle();
        check("wp_low_err", 32'(wp_err), 32'(WP));
        capture(5'd3); read(); idle();
        capture(5'd20); write(8'hAA); idle();
        check("wp_high_err", 32'(wp_err), 32'(WP));
        capture(5'd20); read(); idle();

        // Read with no capture after reset: served from address 0, flagged.
        do_reset();
        read(); idle();
        check("nocap_proto_err", 32'(proto_err), 32'd1);
        capture(5'd20); read(); idle();
        check("nocap_sticky", 32'(proto_err), 32'd1);

        // Conflicting strobes lock the FSM in FAULT until reset.
        do_reset();
        capture(5'd7); write(8'h11); idle();
        capture(5'd7);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'hEE);
        check("conflict_state", 32'(dut.state), 32'(FAULT));
        check("conflict_proto_err", 32'(proto_err), 32'd1);
        idle();
        check("fault_held", 32'(dut.state), 32'(FAULT));
        do_reset();
        check("fault_rst_state", 32'(dut.state), 32'(IDLE));
        check("fault_rst_proto_err", 32'(proto_err), 32'd0);
        check("fault_rst_wp_err", 32'(wp_err), 32'd0);
        capture(5'd7); read(); idle();

        // Reset during a write discards it; reset during a read hides data.
        capture(5'd25); write(8'h77); idle();
        capture(5'd25);
        reset_cycle(1'b0, 1'b1, 1'b0, 8'h99);
        reset_cycle(1'b0, 1'b0, 1'b1, 8'h00);
        capture(5'd25); read(); idle();
        check("reset_mid_proto_err", 32'(proto_err), 32'd0);

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
